// File: rtl/lfsr_share_arbiter_if.sv
// Request/grant bundle between the shared LFSR arbiter and its consumers.
// The slave side is the arbiter; the master side drives requests and seeds.
interface lfsr_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               rnd_valid;
    logic [4:0]         rnd_data;
    logic [ID_W-1:0]    rnd_id;
    logic               seed_load;
    logic [4:0]         seed;
    logic               busy;
    logic [4:0]         lfsr_state;

    modport master (
        output req, seed_load, seed,
        input  gnt, rnd_valid, rnd_data, rnd_id, busy, lfsr_state
    );

    modport slave (
        input  req, seed_load, seed,
        output gnt, rnd_valid, rnd_data, rnd_id, busy, lfsr_state
    );
endinterface

// File: rtl/lfsr_share_arbiter.sv
// Shares one 5-bit Fibonacci LFSR among NUM_REQ requesters via round-robin grants.
// Latency: grant one cycle after the IDLE sampling edge; backpressure: optional gap after each grant.
// Grant period: 2 + GAP_CYCLES cycles.
module lfsr_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAP1       = 0,
    parameter int TAP2       = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    lfsr_share_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state, state_nxt;
    logic [4:0]         lfsr;
    logic [4:0]         lfsr_step;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_wrap;
    logic [ID_W-1:0]    win_nxt;
    logic               any_req;
    logic [7:0]         gap_cnt;
    logic [NUM_REQ-1:0] gnt;
    logic               rnd_valid;
    logic [4:0]         rnd_data;
    logic [ID_W-1:0]    rnd_id;
    logic               busy;

    assign lfsr_step = {lfsr[TAP1] ^ lfsr[TAP2], lfsr[4:1]};
    // rnd_id holds the latched winner for the whole GRANT cycle.
    assign ptr_wrap  = (int'(rnd_id) == NUM_REQ - 1) ? '0 : rnd_id + ID_W'(1);

    always_comb begin
        any_req = 1'b0;
        win_nxt = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any_req && bus.req[idx]) begin
                any_req = 1'b1;
                win_nxt = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bus.seed_load && any_req) state_nxt = GRANT;
            GRANT:   state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= 5'b00001;
            ptr       <= '0;
            gap_cnt   <= 8'd0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= 5'd0;
            rnd_id    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (bus.seed_load) begin
                        lfsr <= (bus.seed == 5'd0) ? 5'b00001 : bus.seed;
                    end else if (any_req) begin
                        gnt       <= NUM_REQ'(1) << win_nxt;
                        rnd_valid <= 1'b1;
                        rnd_data  <= lfsr;
                        rnd_id    <= win_nxt;
                    end
                end
                GRANT: begin
                    lfsr <= lfsr_step;
                    ptr  <= ptr_wrap;
                    if (GAP_CYCLES > 0) gap_cnt <= 8'(GAP_CYCLES - 1);
                end
                GAP: begin
                    if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = gnt;
    assign bus.rnd_valid  = rnd_valid;
    assign bus.rnd_data   = rnd_data;
    assign bus.rnd_id     = rnd_id;
    assign bus.busy       = busy;
    assign bus.lfsr_state = lfsr;
endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Directed bench: table of per-cycle vectors for GAP_CYCLES=0, plus hand sequences
// for fairness, full LFSR period, gap spacing and asynchronous reset.
module tb_lfsr_share_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lfsr_share_arbiter_if #(.NUM_REQ(4)) b0 ();
    lfsr_share_arbiter_if #(.NUM_REQ(4)) b3 ();

    lfsr_share_arbiter #(.NUM_REQ(4), .TAP1(0), .TAP2(2), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    lfsr_share_arbiter #(.NUM_REQ(4), .TAP1(0), .TAP2(2), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic       sl;
        logic [4:0] seed;
        logic [3:0] gnt;
        logic       vld;
        logic [4:0] data;
        logic [1:0] id;
        logic       busy;
        logic [4:0] lfsr;
    } vec_t;

    vec_t tbl[26];

    initial begin
        logic [31:0] seen;
        logic [4:0]  d;
        logic        exp_g;
        logic [4:0]  exp_l;

        // req, seed_load, seed | gnt, valid, data, id, busy, lfsr (after the edge)
        tbl[0]  = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd1,  2'd0, 1'b1, 5'd1};
        tbl[1]  = '{4'h1, 1'b0, 5'd0,  4'h0, 1'b0, 5'd1,  2'd0, 1'b0, 5'd16};
        tbl[2]  = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd16, 2'd0, 1'b1, 5'd16};
        tbl[3]  = '{4'h1, 1'b0, 5'd0,  4'h0, 1'b0, 5'd16, 2'd0, 1'b0, 5'd8};
        tbl[4]  = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd8,  2'd0, 1'b1, 5'd8};
        tbl[5]  = '{4'h1, 1'b0, 5'd0,  4'h0, 1'b0, 5'd8,  2'd0, 1'b0, 5'd4};
        tbl[6]  = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd4,  2'd0, 1'b1, 5'd4};
        tbl[7]  = '{4'h1, 1'b0, 5'd0,  4'h0, 1'b0, 5'd4,  2'd0, 1'b0, 5'd18};
        tbl[8]  = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd18, 2'd0, 1'b1, 5'd18};
        tbl[9]  = '{4'h1, 1'b0, 5'd0,  4'h0, 1'b0, 5'd18, 2'd0, 1'b0, 5'd9};
        tbl[10] = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd9,  2'd0, 1'b1, 5'd9};
        tbl[11] = '{4'h1, 1'b0, 5'd0,  4'h0, 1'b0, 5'd9,  2'd0, 1'b0, 5'd20};
        tbl[12] = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd20, 2'd0, 1'b1, 5'd20};
        tbl[13] = '{4'h0, 1'b0, 5'd0,  4'h0, 1'b0, 5'd20, 2'd0, 1'b0, 5'd26};
        tbl[14] = '{4'h0, 1'b1, 5'd0,  4'h0, 1'b0, 5'd20, 2'd0, 1'b0, 5'd1};
        tbl[15] = '{4'h1, 1'b1, 5'd21, 4'h0, 1'b0, 5'd20, 2'd0, 1'b0, 5'd21};
        tbl[16] = '{4'h1, 1'b0, 5'd0,  4'h1, 1'b1, 5'd21, 2'd0, 1'b1, 5'd21};
        tbl[17] = '{4'h0, 1'b0, 5'd0,  4'h0, 1'b0, 5'd21, 2'd0, 1'b0, 5'd10};
        tbl[18] = '{4'hA, 1'b0, 5'd0,  4'h2, 1'b1, 5'd10, 2'd1, 1'b1, 5'd10};
        tbl[19] = '{4'hA, 1'b0, 5'd0,  4'h0, 1'b0, 5'd10, 2'd1, 1'b0, 5'd5};
        tbl[20] = '{4'hA, 1'b0, 5'd0,  4'h8, 1'b1, 5'd5,  2'd3, 1'b1, 5'd5};
        tbl[21] = '{4'hA, 1'b0, 5'd0,  4'h0, 1'b0, 5'd5,  2'd3, 1'b0, 5'd2};
        tbl[22] = '{4'hA, 1'b0, 5'd0,  4'h2, 1'b1, 5'd2,  2'd1, 1'b1, 5'd2};
        tbl[23] = '{4'hA, 1'b0, 5'd0,  4'h0, 1'b0, 5'd2,  2'd1, 1'b0, 5'd1};
        tbl[24] = '{4'hA, 1'b0, 5'd0,  4'h8, 1'b1, 5'd1,  2'd3, 1'b1, 5'd1};
        tbl[25] = '{4'h0, 1'b0, 5'd0,  4'h0, 1'b0, 5'd1,  2'd3, 1'b0, 5'd16};

        b0.req = '0; b0.seed_load = 1'b0; b0.seed = '0;
        b3.req = '0; b3.seed_load = 1'b0; b3.seed = '0;

        // Asynchronous reset checked before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst gnt",   32'(b0.gnt), 0);
        chk("rst valid", 32'(b0.rnd_valid), 0);
        chk("rst data",  32'(b0.rnd_data), 0);
        chk("rst id",    32'(b0.rnd_id), 0);
        chk("rst busy",  32'(b0.busy), 0);
        chk("rst lfsr",  32'(b0.lfsr_state), 1);
        chk("rst lfsr3", 32'(b3.lfsr_state), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            b0.req = tbl[i].req; b0.seed_load = tbl[i].sl; b0.seed = tbl[i].seed;
            @(posedge clk); #1;
            chk($sformatf("v%0d gnt", i),   32'(b0.gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d valid", i), 32'(b0.rnd_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d data", i),  32'(b0.rnd_data), 32'(tbl[i].data));
            chk($sformatf("v%0d id", i),    32'(b0.rnd_id), 32'(tbl[i].id));
            chk($sformatf("v%0d busy", i),  32'(b0.busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d lfsr", i),  32'(b0.lfsr_state), 32'(tbl[i].lfsr));
        end
        b0.seed_load = 1'b0;

        // All requesters: strict rotation starting from pointer 0.
        b0.req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rr%0d gnt", k), 32'(b0.gnt), 32'(4'h1 << (k % 4)));
            chk($sformatf("rr%0d id", k),  32'(b0.rnd_id), 32'(k % 4));
            @(posedge clk); #1;
            chk($sformatf("rr%0d idle", k), 32'(b0.gnt), 0);
        end
        b0.req = '0;

        // Full period: 31 distinct nonzero values, then back to 1.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        b0.req = 4'h1;
        seen = '0;
        for (int g = 0; g < 32; g++) begin
            @(posedge clk); #1;
            chk($sformatf("per%0d gnt", g), 32'(b0.gnt), 1);
            d = b0.rnd_data;
            if (g < 31) seen[d] = 1'b1;
            else        chk("per wrap data", 32'(d), 1);
            @(posedge clk); #1;
        end
        chk("per coverage", seen, 32'hFFFF_FFFE);
        b0.req = '0;

        // GAP_CYCLES=3: grants 5 apart, busy 4 of 5 cycles, seed ignored while busy.
        b3.req = 4'h1;
        b3.seed = 5'd7;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            exp_g = (c % 5 == 0);
            exp_l = (c == 0) ? 5'd1 : (c <= 5) ? 5'd16 : (c <= 10) ? 5'd8 : 5'd4;
            chk($sformatf("gap%0d gnt", c),  32'(b3.gnt), exp_g ? 1 : 0);
            chk($sformatf("gap%0d busy", c), 32'(b3.busy), (c % 5 != 4) ? 1 : 0);
            chk($sformatf("gap%0d lfsr", c), 32'(b3.lfsr_state), 32'(exp_l));
            if (exp_g) chk($sformatf("gap%0d data", c), 32'(b3.rnd_data),
                           (c == 0) ? 1 : (c == 5) ? 16 : 8);
            b3.seed_load = (c <= 2);
        end
        b3.seed_load = 1'b0;

        // Reset asserted in the middle of GAP, checked without a clock edge.
        rst_n = 1'b0;
        #2;
        chk("mid rst gnt",  32'(b3.gnt), 0);
        chk("mid rst busy", 32'(b3.busy), 0);
        chk("mid rst lfsr", 32'(b3.lfsr_state), 1);
        chk("mid rst vld",  32'(b3.rnd_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
